// File: rtl/pipe_stage_fifo_if.sv
// Valid/ready stream bundle used on both sides of pipe_stage_fifo.
// The producer takes the master modport, the consumer the slave modport.
interface pipe_stage_fifo_if #(
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_fifo.sv
// Elastic DEPTH-entry inter-stage buffer with valid/ready handshake, flush,
// optional fall-through when empty, and occupancy reporting.
module pipe_stage_fifo #(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 2,
  parameter int FALLTHROUGH = 0,
  parameter int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  pipe_stage_fifo_if.slave   up_if,
  pipe_stage_fifo_if.master  dn_if,
  output logic [CNT_W-1:0]   count_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic full_s;
  logic empty_s;
  logic valid_s;
  logic push_s;
  logic pop_s;
  logic pass_s;
  logic we_s;

  // Occupancy flags come only from the counter so wrapped pointers never alias.
  always_comb begin
    full_s  = (count_q == CNT_W'(DEPTH));
    empty_s = (count_q == {CNT_W{1'b0}});
  end

  // Handshake qualification; pass_s marks an entry that bypasses storage.
  always_comb begin
    if (rst_i) begin
      valid_s = 1'b0;
    end else if (FALLTHROUGH != 0) begin
      valid_s = !empty_s || up_if.valid;
    end else begin
      valid_s = !empty_s;
    end
    push_s = up_if.valid && !full_s;
    pop_s  = valid_s && dn_if.ready;
    pass_s = (FALLTHROUGH != 0) && empty_s && push_s && pop_s;
    we_s   = push_s && !pass_s && !flush_i;
  end

  // Next pointer and occupancy state; flush wins over any handshake.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else if (pass_s) begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          count_d  = count_q + CNT_W'(1);
        end
        2'b01: begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          count_d  = count_q - CNT_W'(1);
        end
        2'b11: begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        default: begin
          rd_ptr_d = rd_ptr_q;
          wr_ptr_d = wr_ptr_q;
          count_d  = count_q;
        end
      endcase
    end
  end

  // Next storage contents: only the slot under the write pointer can change.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    mem_d[wr_ptr_q] = we_s ? up_if.data : mem_q[wr_ptr_q];
  end

  // Output drive; an empty fall-through buffer mirrors the upstream payload.
  always_comb begin
    up_if.ready = !full_s;
    dn_if.valid = valid_s;
    if (rst_i) begin
      dn_if.data = {DATA_W{1'b0}};
    end else if ((FALLTHROUGH != 0) && empty_s) begin
      dn_if.data = up_if.data;
    end else if (valid_s) begin
      dn_if.data = mem_q[rd_ptr_q];
    end else begin
      dn_if.data = {DATA_W{1'b0}};
    end
    count_o = count_q;
    full_o  = full_s;
    empty_o = empty_s;
  end

  // Control state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; unread slots are never observed.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

`ifdef ASSERTIONS
  // Structural safety properties of the occupancy logic.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push_s && full_s));
      assert (count_q <= CNT_W'(DEPTH));
    end
  end
`endif

endmodule

// File: doc/pipe_stage_fifo.md
Name: pipe_stage_fifo

Overview:
Elastic inter-stage pipeline buffer. It replaces the fixed single-entry flush/load stage register with a parametrised DEPTH-entry FIFO that uses a valid/ready handshake. It sits between pipeline stages (for example decode to RR, or exe to WB) so that a downstream stall is absorbed without back-propagating combinationally. It supports pipeline flush, an optional fall-through mode, and occupancy reporting for the control unit.

Parameters:
DATA_W, 64, payload width in bits (≥1).
DEPTH, 2, number of entries; power of two, ≥2.
FALLTHROUGH, 0, 0 = registered output (min latency 1 cycle); 1 = when empty, input appears on output in the same cycle.
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override).

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  asynchronous reset, active-high.
flush_i  in  1  synchronous flush: discard all entries.
valid_i  in  1  upstream presents data_i.
data_i  in  DATA_W  upstream payload.
ready_o  out  1  buffer can accept this cycle.
valid_o  out  1  data_o holds the oldest entry.
data_o  out  DATA_W  oldest entry payload.
ready_i  in  1  downstream accepts data_o this cycle.
count_o  out  CNT_W  current occupancy, 0..DEPTH.
full_o  out  1  count_o == DEPTH.
empty_o  out  1  count_o == 0.

Behaviour:
- Storage: DEPTH×DATA_W array; rd_ptr and wr_ptr are log2(DEPTH) bits wide, increment modulo DEPTH, and wrap naturally. Occupancy is held in a CNT_W register; full and empty are decoded from the counter, never from pointer equality alone.
- Reset (rst_i high, async): rd_ptr = wr_ptr = 0, count = 0. Outputs: valid_o = 0, ready_o = 1, full_o = 0, empty_o = 1, count_o = 0, data_o = 0. Array contents are don't-care. When reset asserts mid-transfer, in-flight entries are lost and no handshake completes that cycle.
- push = valid_i && ready_o; pop = valid_o && ready_i.
- ready_o = !full_o. It has no combinational dependence on ready_i. A full buffer does not accept a push even if a pop occurs in the same cycle.
- FALLTHROUGH = 0:
  - valid_o = !empty_o; data_o = array[rd_ptr] while valid, else 0.
  - A push into an empty buffer is visible on valid_o the next cycle.
- FALLTHROUGH = 1:
  - valid_o = !empty_o || valid_i.
  - When empty, data_o = data_i. If push && pop occur while empty, the entry passes through: no write, pointers and count unchanged.
  - In this mode valid_o depends combinationally on valid_i (documented path).
- Simultaneous push and pop (non-empty, not full): write at wr_ptr, read from rd_ptr, both pointers advance, count unchanged.
- Flush (flush_i high at an edge): the next state is empty (ptrs = 0, count = 0), regardless of push or pop that cycle. The pending push is dropped. The pop handshake still counts as completed for the downstream, which must itself honour the flush. flush_i does not gate valid_o or ready_o combinationally.
- Flush and reset together: reset dominates.
- count_o, full_o and empty_o are registered-state derived. They reflect the post-edge state and have no combinational input paths.
- Ordering: strict FIFO. No entry is duplicated or skipped across pointer wrap.
- No overflow or underflow is possible by construction. With ASSERTIONS defined, the block asserts !(push && full_o) and count_o ≤ DEPTH.

Test Plan:
1. DEPTH=4, DATA_W=8, FT=0: reset, push 0x11,0x22,0x33,0x44 with ready_i=0 -> full_o=1, ready_o=0, count_o=4. A fifth push of 0x55 is ignored. Then ready_i=1 pops 0x11,0x22,0x33,0x44 in order, then empty_o=1, valid_o=0.
2. Wrap-around, DEPTH=4: continuous push and pop of 0x00..0x0F with ready_i=1 after a 2-entry prefill -> output sequence 0x00..0x0F in order, count_o steady at 2, pointers wrap 3 times.
3. Flush: with 3 entries held and push 0x77 plus pop in the same cycle as flush_i=1 -> the next cycle shows count_o=0, valid_o=0, ready_o=1. A subsequent push of 0x88 is the next output; 0x77 never appears.
4. FALLTHROUGH=1, empty: valid_i=1, data_i=0xA5, ready_i=1 -> valid_o=1 and data_o=0xA5 the same cycle; count_o stays 0. With ready_i=0 instead, the next cycle shows count_o=1 and data_o=0xA5.
5. Full plus simultaneous pop, DEPTH=2: buffer full with 0x01,0x02, valid_i=1 with data 0x03, ready_i=1 -> 0x01 pops, 0x03 is not accepted, and count_o=1 the next cycle.
6. Async reset mid-stream: assert rst_i between clock edges with 2 entries held -> outputs reach their reset values immediately without a clock edge. After deassertion, the first push of 0x5A is output first.
